// File: rtl/dma_l2_arbiter_if.sv
// Bundle of the DMA request/response ports and the L2 master port of dma_l2_arbiter.
// The master modport is the arbiter view and the slave modport is the environment view.
interface dma_l2_arbiter_if #(
    parameter int NumPorts       = 4,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 64,
    parameter int MaxOutstanding = 8
) ();
    localparam int StrbWidth = DataWidth / 8;
    localparam int CntWidth  = $clog2(MaxOutstanding) + 1;

    logic [AddrWidth-1:0]                 l2_start_addr_i;
    logic [AddrWidth-1:0]                 l2_end_addr_i;

    logic [NumPorts-1:0]                  req_valid_i;
    logic [NumPorts-1:0]                  req_ready_o;
    logic [NumPorts-1:0][AddrWidth-1:0]   req_addr_i;
    logic [NumPorts-1:0]                  req_we_i;
    logic [NumPorts-1:0][DataWidth-1:0]   req_wdata_i;
    logic [NumPorts-1:0][StrbWidth-1:0]   req_strb_i;

    logic [NumPorts-1:0]                  rsp_valid_o;
    logic [NumPorts-1:0]                  rsp_ready_i;
    logic [DataWidth-1:0]                 rsp_rdata_o;
    logic                                 rsp_err_o;

    logic                                 l2_req_valid_o;
    logic                                 l2_req_ready_i;
    logic [AddrWidth-1:0]                 l2_addr_o;
    logic                                 l2_we_o;
    logic [DataWidth-1:0]                 l2_wdata_o;
    logic [StrbWidth-1:0]                 l2_strb_o;

    logic                                 l2_rsp_valid_i;
    logic                                 l2_rsp_ready_o;
    logic [DataWidth-1:0]                 l2_rsp_rdata_i;
    logic                                 l2_rsp_err_i;

    logic [CntWidth-1:0]                  outstanding_o;

    modport master (
        input  l2_start_addr_i, l2_end_addr_i,
        input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_strb_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output l2_req_valid_o, l2_addr_o, l2_we_o, l2_wdata_o, l2_strb_o,
        input  l2_req_ready_i,
        input  l2_rsp_valid_i, l2_rsp_rdata_i, l2_rsp_err_i,
        output l2_rsp_ready_o,
        output outstanding_o
    );

    modport slave (
        output l2_start_addr_i, l2_end_addr_i,
        output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_strb_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  l2_req_valid_o, l2_addr_o, l2_we_o, l2_wdata_o, l2_strb_o,
        output l2_req_ready_i,
        output l2_rsp_valid_i, l2_rsp_rdata_i, l2_rsp_err_i,
        input  l2_rsp_ready_o,
        input  outstanding_o
    );
endinterface

// File: rtl/dma_l2_arbiter.sv
// Round-robin N:1 arbiter from cluster DMA ports to L2 with in-order response routing.
// Define DMA_L2_ARBITER_ADDR_CHECK_EN to answer out-of-window requests locally with an error.
module dma_l2_arbiter #(
    parameter int NumPorts       = 4,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 64,
    parameter int MaxOutstanding = 8
) (
    input logic              clk_i,
    input logic              rst_i,
    dma_l2_arbiter_if.master bus
);
    localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int FW = $clog2(MaxOutstanding);
    localparam int SW = DataWidth / 8;

    logic [PW-1:0]        rr_q;

    logic                 oreg_valid_q;
    logic [AddrWidth-1:0] oreg_addr_q;
    logic                 oreg_we_q;
    logic [DataWidth-1:0] oreg_wdata_q;
    logic [SW-1:0]        oreg_strb_q;

    logic [PW-1:0]        fifo_port_q [MaxOutstanding];
    logic                 fifo_err_q  [MaxOutstanding];
    logic [FW-1:0]        wptr_q;
    logic [FW-1:0]        rptr_q;
    logic [FW:0]          count_q;

    logic [NumPorts-1:0]  addr_err;
    logic [NumPorts-1:0]  eligible;
    logic                 can_fwd;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 gnt_any;
    logic [PW-1:0]        gnt_idx;
    logic [PW-1:0]        cand;
    logic                 gnt_err;
    logic                 load;
    logic                 push;
    logic                 pop;
    logic [PW-1:0]        head_port;
    logic                 head_err;

`ifdef DMA_L2_ARBITER_ADDR_CHECK_EN
    always_comb begin
        addr_err = '0;
        for (int p = 0; p < NumPorts; p++) begin
            addr_err[p] = (bus.req_addr_i[p] < bus.l2_start_addr_i) ||
                          (bus.req_addr_i[p] >= bus.l2_end_addr_i);
        end
    end
`else
    logic unused_window;
    assign unused_window = ^{bus.l2_start_addr_i, bus.l2_end_addr_i};
    assign addr_err      = '0;
`endif

    assign fifo_full  = (count_q == (FW+1)'(MaxOutstanding));
    assign fifo_empty = (count_q == '0);
    assign can_fwd    = !oreg_valid_q || bus.l2_req_ready_i;

    // Error requests are answered locally, so they skip the output register check.
    assign eligible = bus.req_valid_i & (addr_err | {NumPorts{can_fwd}});

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < NumPorts; i++) begin
            cand = PW'((int'(rr_q) + i) % NumPorts);
            if (!gnt_any && eligible[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (rst_i || fifo_full) begin
            gnt_any = 1'b0;
        end
    end

    assign gnt_err         = addr_err[gnt_idx];
    assign push            = gnt_any;
    assign load            = gnt_any && !gnt_err;
    assign bus.req_ready_o = gnt_any ? (NumPorts'(1) << gnt_idx) : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else if (gnt_any) begin
            rr_q <= (gnt_idx == PW'(NumPorts - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            oreg_valid_q <= 1'b0;
            oreg_addr_q  <= '0;
            oreg_we_q    <= 1'b0;
            oreg_wdata_q <= '0;
            oreg_strb_q  <= '0;
        end else if (load) begin
            oreg_valid_q <= 1'b1;
            oreg_addr_q  <= bus.req_addr_i[gnt_idx];
            oreg_we_q    <= bus.req_we_i[gnt_idx];
            oreg_wdata_q <= bus.req_wdata_i[gnt_idx];
            oreg_strb_q  <= bus.req_strb_i[gnt_idx];
        end else if (bus.l2_req_ready_i) begin
            oreg_valid_q <= 1'b0;
        end
    end

    assign bus.l2_req_valid_o = oreg_valid_q;
    assign bus.l2_addr_o      = oreg_addr_q;
    assign bus.l2_we_o        = oreg_we_q;
    assign bus.l2_wdata_o     = oreg_wdata_q;
    assign bus.l2_strb_o      = oreg_strb_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_port_q[wptr_q] <= gnt_idx;
            fifo_err_q[wptr_q]  <= gnt_err;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + (FW+1)'(push) - (FW+1)'(pop);
        end
    end

    assign head_port         = fifo_port_q[rptr_q];
    assign head_err          = fifo_err_q[rptr_q];
    assign bus.outstanding_o = count_q;

    always_comb begin
        bus.rsp_valid_o    = '0;
        bus.rsp_rdata_o    = '0;
        bus.rsp_err_o      = 1'b0;
        bus.l2_rsp_ready_o = 1'b0;
        pop                = 1'b0;
        if (!fifo_empty) begin
            if (head_err) begin
                bus.rsp_valid_o[head_port] = 1'b1;
                bus.rsp_err_o              = 1'b1;
                pop                        = bus.rsp_ready_i[head_port];
            end else begin
                bus.rsp_valid_o[head_port] = bus.l2_rsp_valid_i;
                bus.rsp_rdata_o            = bus.l2_rsp_rdata_i;
                bus.rsp_err_o              = bus.l2_rsp_err_i;
                bus.l2_rsp_ready_o         = bus.rsp_ready_i[head_port];
                pop = bus.l2_rsp_valid_i && bus.rsp_ready_i[head_port];
            end
        end
    end
endmodule

// File: tb/tb_dma_l2_arbiter.sv
// Self-checking bench for dma_l2_arbiter: vector table, corner sequences
// and a randomized run against a queue-based reference model.
module tb_dma_l2_arbiter;
    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MO = 8;
    localparam int SW = DW / 8;
    localparam logic [AW-1:0] WIN_LO = 32'h1000_0000;
    localparam logic [AW-1:0] WIN_HI = 32'h1010_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_l2_arbiter_if #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW),
                        .MaxOutstanding(MO)) bus ();

    dma_l2_arbiter #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW),
                     .MaxOutstanding(MO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [NP-1:0] valid;
        logic [NP-1:0] exp_ready;
    } vec_t;
    vec_t tbl[8];

    // reference model state
    int            rr_m;
    bit            ov_m;
    logic [AW-1:0] oa_m;
    logic          owe_m;
    logic [DW-1:0] ow_m;
    logic [SW-1:0] os_m;
    int            rq_port[$];
    bit            rq_err[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [AW-1:0] port_addr(input int p);
        return WIN_LO + AW'(p) * 32'h40;
    endfunction

    function automatic bit oob(input logic [AW-1:0] a);
`ifdef DMA_L2_ARBITER_ADDR_CHECK_EN
        return (a < WIN_LO) || (a >= WIN_HI);
`else
        return a == a ? 1'b0 : 1'b0;
`endif
    endfunction

    function automatic int onehot_idx(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic idle();
        bus.l2_start_addr_i = WIN_LO;
        bus.l2_end_addr_i   = WIN_HI;
        bus.req_valid_i     = '0;
        bus.req_we_i        = '0;
        for (int p = 0; p < NP; p++) begin
            bus.req_addr_i[p]  = port_addr(p);
            bus.req_wdata_i[p] = {32'hA5A5_0000 + 32'(p), 32'h0};
            bus.req_strb_i[p]  = '1;
        end
        bus.rsp_ready_i    = '1;
        bus.l2_req_ready_i = 1'b1;
        bus.l2_rsp_valid_i = 1'b0;
        bus.l2_rsp_rdata_i = '0;
        bus.l2_rsp_err_i   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready_o, 0);
        chk("rst_l2_valid", bus.l2_req_valid_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_l2_rsp_ready", bus.l2_rsp_ready_o, 0);
        chk("rst_outstanding", bus.outstanding_o, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic model_cycle();
        bit            cf;
        int            win;
        int            p;
        bit            e;
        bit            pop;
        int            hp;
        logic [NP-1:0] er;
        logic [NP-1:0] ev;
        cf  = !ov_m || bus.l2_req_ready_i;
        win = -1;
        if (rq_port.size() < MO) begin
            for (int i = 0; i < NP; i++) begin
                p = (rr_m + i) % NP;
                if (win < 0 && bus.req_valid_i[p] &&
                    (cf || oob(bus.req_addr_i[p]))) win = p;
            end
        end
        er = (win >= 0) ? NP'(1) << win : '0;
        chk("rnd_req_ready", bus.req_ready_o, er);
        chk("rnd_l2_valid", bus.l2_req_valid_o, ov_m);
        if (ov_m) begin
            chk("rnd_l2_addr", bus.l2_addr_o, oa_m);
            chk("rnd_l2_we", bus.l2_we_o, owe_m);
            chk("rnd_l2_wdata", bus.l2_wdata_o, ow_m);
            chk("rnd_l2_strb", bus.l2_strb_o, os_m);
        end
        chk("rnd_outstanding", bus.outstanding_o, rq_port.size());
        pop = 1'b0;
        if (rq_port.size() == 0) begin
            chk("rnd_rsp_valid", bus.rsp_valid_o, 0);
            chk("rnd_l2_rsp_ready", bus.l2_rsp_ready_o, 0);
        end else begin
            hp = rq_port[0];
            if (rq_err[0]) begin
                chk("rnd_rsp_valid", bus.rsp_valid_o, NP'(1) << hp);
                chk("rnd_rsp_err", bus.rsp_err_o, 1);
                chk("rnd_rsp_rdata", bus.rsp_rdata_o, 0);
                chk("rnd_l2_rsp_ready", bus.l2_rsp_ready_o, 0);
                pop = bus.rsp_ready_i[hp];
            end else begin
                ev = bus.l2_rsp_valid_i ? NP'(1) << hp : '0;
                chk("rnd_rsp_valid", bus.rsp_valid_o, ev);
                chk("rnd_l2_rsp_ready", bus.l2_rsp_ready_o, bus.rsp_ready_i[hp]);
                if (bus.l2_rsp_valid_i) begin
                    chk("rnd_rsp_rdata", bus.rsp_rdata_o, bus.l2_rsp_rdata_i);
                    chk("rnd_rsp_err", bus.rsp_err_o, bus.l2_rsp_err_i);
                end
                pop = bus.l2_rsp_valid_i && bus.rsp_ready_i[hp];
            end
        end
        if (pop) begin
            void'(rq_port.pop_front());
            void'(rq_err.pop_front());
        end
        if (ov_m && bus.l2_req_ready_i) ov_m = 1'b0;
        if (win >= 0) begin
            e    = oob(bus.req_addr_i[win]);
            rr_m = (win + 1) % NP;
            rq_port.push_back(win);
            rq_err.push_back(e);
            if (!e) begin
                ov_m  = 1'b1;
                oa_m  = bus.req_addr_i[win];
                owe_m = bus.req_we_i[win];
                ow_m  = bus.req_wdata_i[win];
                os_m  = bus.req_strb_i[win];
            end
        end
    endtask

    initial begin
        int prev;
        int cnt;
        int seq[4];
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;

        tbl[0] = '{4'b0101, 4'b0001};
        tbl[1] = '{4'b0101, 4'b0100};
        tbl[2] = '{4'b0101, 4'b0001};
        tbl[3] = '{4'b1000, 4'b1000};
        tbl[4] = '{4'b1111, 4'b0001};
        tbl[5] = '{4'b1111, 4'b0010};
        tbl[6] = '{4'b0000, 4'b0000};
        tbl[7] = '{4'b0011, 4'b0001};

        // arbitration vector table, responses drained every cycle
        do_reset();
        bus.l2_rsp_valid_i = 1'b1;
        prev = -1;
        for (int i = 0; i < 8; i++) begin
            bus.req_valid_i = tbl[i].valid;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), bus.req_ready_o, tbl[i].exp_ready);
            chk($sformatf("tbl%0d_l2_valid", i), bus.l2_req_valid_o, prev >= 0);
            if (prev >= 0)
                chk($sformatf("tbl%0d_l2_addr", i), bus.l2_addr_o, port_addr(prev));
            prev = onehot_idx(tbl[i].exp_ready);
            tick();
        end

        // ports 0 and 2 continuous: alternate grants, forwarded next cycle
        do_reset();
        seq = '{0, 2, 0, 2};
        bus.req_valid_i = 4'b0101;
        bus.l2_rsp_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("alt_ready", bus.req_ready_o, NP'(1) << seq[i]);
            if (i > 0) chk("alt_l2_addr", bus.l2_addr_o, port_addr(seq[i-1]));
            tick();
        end
        @(negedge clk);
        chk("alt_l2_addr_last", bus.l2_addr_o, port_addr(2));

        // fill the routing FIFO while L2 withholds responses
        do_reset();
        bus.req_valid_i = '1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.req_ready_o != 0) cnt++;
            tick();
        end
        @(negedge clk);
        chk("full_grants", cnt, MO);
        chk("full_outstanding", bus.outstanding_o, MO);
        chk("full_ready", bus.req_ready_o, 0);
        tick();
        bus.l2_rsp_valid_i = 1'b1;
        @(negedge clk);
        chk("full_pop_ready", bus.req_ready_o, 0);
        chk("full_pop_rsp_valid", bus.rsp_valid_o, 4'b0001);
        chk("full_pop_l2_rsp_ready", bus.l2_rsp_ready_o, 1);
        tick();
        bus.l2_rsp_valid_i = 1'b0;
        @(negedge clk);
        chk("full_after_outstanding", bus.outstanding_o, MO - 1);
        chk("full_after_ready", bus.req_ready_o, 4'b0001);

        // L2 request stall: payload held, no new grant
        do_reset();
        bus.l2_req_ready_i = 1'b0;
        bus.req_valid_i = 4'b0001;
        a0 = port_addr(0);
        d0 = bus.req_wdata_i[0];
        @(negedge clk);
        chk("stall_first_ready", bus.req_ready_o, 4'b0001);
        tick();
        bus.req_addr_i[0]  = 32'h1000_0800;
        bus.req_wdata_i[0] = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready", bus.req_ready_o, 0);
            chk("stall_l2_valid", bus.l2_req_valid_o, 1);
            chk("stall_addr", bus.l2_addr_o, a0);
            chk("stall_wdata", bus.l2_wdata_o, d0);
            tick();
        end
        bus.l2_req_ready_i = 1'b1;
        @(negedge clk);
        chk("stall_drain_ready", bus.req_ready_o, 4'b0001);

        // head port not ready: L2 response held, nobody else answered
        do_reset();
        bus.req_valid_i = 4'b0100;
        tick();
        bus.req_valid_i    = '0;
        bus.l2_rsp_valid_i = 1'b1;
        bus.l2_rsp_rdata_i = 64'hDEAD_BEEF_0BAD_F00D;
        bus.rsp_ready_i    = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_l2_rsp_ready", bus.l2_rsp_ready_o, 0);
            chk("hold_rsp_valid", bus.rsp_valid_o, 4'b0100);
            chk("hold_rdata", bus.rsp_rdata_o, 64'hDEAD_BEEF_0BAD_F00D);
            chk("hold_outstanding", bus.outstanding_o, 1);
            tick();
        end
        bus.rsp_ready_i = '1;
        @(negedge clk);
        chk("hold_release_l2_rsp_ready", bus.l2_rsp_ready_o, 1);
        tick();
        @(negedge clk);
        chk("hold_release_outstanding", bus.outstanding_o, 0);
        chk("hold_release_rsp_valid", bus.rsp_valid_o, 0);

        // reset with three transactions in flight
        do_reset();
        bus.req_valid_i = '1;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", bus.req_ready_o, 0);
        chk("mid_rst_l2_valid", bus.l2_req_valid_o, 0);
        chk("mid_rst_l2_addr", bus.l2_addr_o, 0);
        chk("mid_rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("mid_rst_rdata", bus.rsp_rdata_o, 0);
        chk("mid_rst_l2_rsp_ready", bus.l2_rsp_ready_o, 0);
        chk("mid_rst_outstanding", bus.outstanding_o, 0);
        tick();
        rst = 1'b0;
        bus.l2_rsp_valid_i = 1'b1;
        @(negedge clk);
        chk("post_rst_outstanding", bus.outstanding_o, 0);
        chk("post_rst_ready", bus.req_ready_o, 4'b0001);
        chk("post_rst_rsp_valid", bus.rsp_valid_o, 0);
        tick();

`ifdef DMA_L2_ARBITER_ADDR_CHECK_EN
        // out-of-window read answered locally ahead of the in-window read
        do_reset();
        bus.req_valid_i   = 4'b0010;
        bus.req_addr_i[1] = 32'h2000_0000;
        @(negedge clk);
        chk("win_err_ready", bus.req_ready_o, 4'b0010);
        tick();
        bus.req_valid_i   = 4'b1000;
        bus.req_addr_i[3] = 32'h1000_0040;
        @(negedge clk);
        chk("win_ok_ready", bus.req_ready_o, 4'b1000);
        chk("win_err_not_fwd", bus.l2_req_valid_o, 0);
        tick();
        bus.req_valid_i    = '0;
        bus.l2_rsp_valid_i = 1'b1;
        bus.l2_rsp_rdata_i = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        chk("win_fwd_addr", bus.l2_addr_o, 32'h1000_0040);
        chk("win_err_rsp_valid", bus.rsp_valid_o, 4'b0010);
        chk("win_err_rsp_err", bus.rsp_err_o, 1);
        chk("win_err_rdata", bus.rsp_rdata_o, 0);
        chk("win_err_l2_rsp_ready", bus.l2_rsp_ready_o, 0);
        tick();
        @(negedge clk);
        chk("win_ok_rsp_valid", bus.rsp_valid_o, 4'b1000);
        chk("win_ok_rdata", bus.rsp_rdata_o, 64'h0123_4567_89AB_CDEF);
        chk("win_ok_rsp_err", bus.rsp_err_o, 0);
        chk("win_ok_l2_rsp_ready", bus.l2_rsp_ready_o, 1);
        tick();
`endif

        // randomized traffic against the reference model
        do_reset();
        rr_m = 0;
        ov_m = 1'b0;
        rq_port.delete();
        rq_err.delete();
        for (int c = 0; c < 3000; c++) begin
            bus.req_valid_i = NP'($urandom_range(0, 15));
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 5) == 0)
                    bus.req_addr_i[p] = $urandom;
                else
                    bus.req_addr_i[p] = WIN_LO + AW'($urandom_range(0, 32'hF_FFF8));
                bus.req_we_i[p]    = 1'($urandom_range(0, 1));
                bus.req_wdata_i[p] = {$urandom, $urandom};
                bus.req_strb_i[p]  = SW'($urandom);
            end
            bus.l2_req_ready_i = ($urandom_range(0, 3) != 0);
            bus.l2_rsp_valid_i = ($urandom_range(0, 2) != 0);
            bus.l2_rsp_rdata_i = {$urandom, $urandom};
            bus.l2_rsp_err_i   = ($urandom_range(0, 7) == 0);
            bus.rsp_ready_i    = NP'($urandom_range(0, 15)) | NP'($urandom_range(0, 15));
            @(negedge clk);
            model_cycle();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dma_l2_arbiter.md
DMA_L2_ARBITER -- requirements
Module: dma_l2_arbiter

Interface
REQ-001 Parameter NumPorts, default 4: number of cluster DMA request ports; legal range 2..16.
REQ-002 Parameter AddrWidth, default 32: address width. Parameter DataWidth, default 64: data width; a multiple of 8.
REQ-003 Parameter MaxOutstanding, default 8: depth of the response-routing FIFO; a power of two, 2..64.
REQ-004 clk_i  in  1  single clock; all state is updated on the rising edge.
REQ-005 rst_i  in  1  reset; asynchronous, active-high.
REQ-006 l2_start_addr_i / l2_end_addr_i  in  AddrWidth each  L2 window, [start, end).
REQ-007 req_valid_i / req_ready_o  in / out  NumPorts each  per-port request handshake.
REQ-008 req_addr_i  in  NumPorts x AddrWidth; req_we_i  in  NumPorts; req_wdata_i  in  NumPorts x DataWidth; req_strb_i  in  NumPorts x DataWidth/8.
REQ-009 rsp_valid_o / rsp_ready_i  out / in  NumPorts each  per-port response handshake.
REQ-010 rsp_rdata_o  out  DataWidth; rsp_err_o  out  1; both shared by all ports and qualified by rsp_valid_o.
REQ-011 l2_req_valid_o / l2_req_ready_i  out / in  1 each; l2_addr_o, l2_we_o, l2_wdata_o, l2_strb_o  out  (widths as REQ-008 per port).
REQ-012 l2_rsp_valid_i / l2_rsp_ready_o  in / out  1 each; l2_rsp_rdata_i  in  DataWidth; l2_rsp_err_i  in  1. L2 answers strictly in request order.
REQ-013 outstanding_o  out  clog2(MaxOutstanding)+1  current routing FIFO occupancy.

Function
REQ-014 Requests are single-beat; a request is accepted on port p when req_valid_i[p] and req_ready_o[p] are both high.
REQ-015 Round-robin arbitration: after a grant to port k, port (k+1) mod NumPorts has highest priority next; the pointer starts at 0.
REQ-016 At most one req_ready_o bit is high per cycle, and only for the winning valid port.
REQ-017 No grant while outstanding_o == MaxOutstanding, even if a pop occurs in the same cycle.
REQ-018 Forwarded requests pass through a one-entry output register: a request accepted at cycle t drives l2_req_valid_o from cycle t+1.
REQ-019 The output register accepts a new request when it is empty or is being drained (l2_req_ready_i high) in the same cycle.
REQ-020 While l2_req_valid_o is high and l2_req_ready_i is low, the l2_* payload holds stable.
REQ-021 Each accepted request pushes {port index, err flag} into the routing FIFO in the cycle it is accepted.
REQ-022 Response head entry with err=0: rsp_valid_o[p] = l2_rsp_valid_i; l2_rsp_ready_o = rsp_ready_i[p]; rsp_rdata_o / rsp_err_o pass from L2.
REQ-023 Response head entry with err=1: rsp_valid_o[p] = 1, rsp_err_o = 1, rsp_rdata_o = 0; no L2 response is consumed.
REQ-024 The FIFO pops on the response handshake; a push and a pop in the same cycle leave occupancy unchanged.
REQ-025 With the routing FIFO empty, all rsp_valid_o bits are 0 and l2_rsp_ready_o is 0.

Reset
REQ-026 On rst_i, all of the following are cleared and all outputs go to 0 within the same cycle: output register, FIFO pointers, outstanding_o, round-robin pointer.
REQ-027 Reset mid-operation discards in-flight requests and routing entries; no response is produced for them after reset release.

Configuration
REQ-028 Macro DMA_L2_ARBITER_ADDR_CHECK_EN defined:
  - a request whose address is outside [l2_start_addr_i, l2_end_addr_i) is not forwarded and is pushed with err=1;
  - such a request does not need the output register to be free.
REQ-029 Macro undefined: every request is forwarded with err=0, and the window inputs are ignored.

Verification
REQ-030 Ports 0 and 2 request continuously; l2_req_ready_i=1 -> grants alternate 0,2,0,2; each appears on l2 one cycle after acceptance.
REQ-031 MaxOutstanding=8; L2 withholds responses -> 8 grants, outstanding_o=8, all req_ready_o=0 until the first response handshake.
REQ-032 l2_req_ready_i held low for 5 cycles -> l2_addr_o/l2_wdata_o stable for those 5 cycles; no further grant.
REQ-033 CHECK_EN, window 0x1000_0000-0x1010_0000: port 1 reads 0x2000_0000, then port 3 reads 0x1000_0040 -> port 1 gets rsp_err_o=1 and rdata 0 first, then port 3 gets the L2 data.
REQ-034 rsp_ready_i[p]=0 for a port-p head entry -> l2_rsp_ready_o=0, the L2 response is held, and no other port receives a response.
REQ-035 rst_i asserted with 3 transactions outstanding -> all outputs 0 immediately; after release outstanding_o=0 and the pointer restarts at port 0.
